// File: rtl/sram_pkg.sv
// Shared types and constants for the parametrised 1R1W SRAM model.
package sram_pkg;
  typedef enum logic {RUN = 1'b0, CLEAR = 1'b1} sram_state_e;

  localparam int SRAM_BYTE_W     = 8;
  localparam int SRAM_RD_LAT_MIN = 1;
  localparam int SRAM_RD_LAT_MAX = 2;
endpackage

// File: rtl/sram_init_seq.sv
// Power-up clear sequencer: sweeps every word to zero after reset.
// Only compiled when SRAM_INIT_CLEAR_EN is defined.
`ifdef SRAM_INIT_CLEAR_EN
module sram_init_seq
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);
  sram_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

  // State and pointer registers; reset (re)starts the sweep at word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // One zero-write per CLEAR cycle; leave after the last word is written.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_we  = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        if (ptr_q == ADDR_WIDTH'(DEPTH - 1)) state_d = RUN;
        else                                 ptr_d   = ptr_q + 1'b1;
      end
      default: ;
    endcase
  end

  assign init_busy = (state_q == CLEAR);
  assign clr_addr  = ptr_q;
endmodule
`endif

// File: rtl/sram_1r1w_sp_param.sv
// Parametrised single-clock 1R1W SRAM model with byte-masked writes,
// write-first collision forwarding and a 1- or 2-cycle read pipeline.
// Optional power-up clear under SRAM_INIT_CLEAR_EN.
module sram_1r1w_sp_param
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int DEPTH      = 1 << ADDR_WIDTH,
  parameter int RD_LAT     = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_en,
  input  logic [ADDR_WIDTH-1:0]             wr_addr,
  input  logic [DATA_WIDTH-1:0]             wr_data,
  input  logic [DATA_WIDTH/SRAM_BYTE_W-1:0] wr_mask,
  input  logic                              rd_en,
  input  logic [ADDR_WIDTH-1:0]             rd_addr,
  output logic [DATA_WIDTH-1:0]             rd_data,
  output logic                              rd_valid,
  output logic                              coll,
  output logic                              init_busy
);
  localparam int NB = DATA_WIDTH / SRAM_BYTE_W;

  if (RD_LAT < SRAM_RD_LAT_MIN || RD_LAT > SRAM_RD_LAT_MAX) begin : g_bad_rd_lat
    $error("sram_1r1w_sp_param: RD_LAT must be 1 or 2");
  end
  if (DATA_WIDTH % SRAM_BYTE_W != 0) begin : g_bad_width
    $error("sram_1r1w_sp_param: DATA_WIDTH must be a multiple of 8");
  end
  if (DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("sram_1r1w_sp_param: DEPTH exceeds address space");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

`ifdef SRAM_INIT_CLEAR_EN
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  sram_init_seq #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_init (
    .clk       (clk),
    .rst       (rst),
    .init_busy (init_busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );
`else
  assign init_busy = 1'b0;
`endif

  logic wr_in_range, rd_in_range, wr_ok, rd_fire, hit;
  logic [DATA_WIDTH-1:0] rd_word, merged;

  // Requests are dead while clearing or in reset; out-of-range writes vanish.
  assign wr_in_range = 32'(wr_addr) < DEPTH;
  assign rd_in_range = 32'(rd_addr) < DEPTH;
  assign wr_ok       = wr_en & ~init_busy & ~rst & wr_in_range;
  assign rd_fire     = rd_en & ~init_busy & ~rst;
  assign hit         = wr_ok & (wr_addr == rd_addr);

  // Write-first merge: masked bytes of a colliding write override old data.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) rd_word = mem[rd_addr];
    merged = rd_word;
    for (int b = 0; b < NB; b++)
      if (hit && wr_mask[b])
        merged[b*SRAM_BYTE_W +: SRAM_BYTE_W] = wr_data[b*SRAM_BYTE_W +: SRAM_BYTE_W];
  end

  // Array write port: clear sweep has priority (user writes are blocked then anyway).
  always_ff @(posedge clk) begin
`ifdef SRAM_INIT_CLEAR_EN
    if (clr_we && !rst) mem[clr_addr] <= '0;
    else
`endif
    if (wr_ok) begin
      for (int b = 0; b < NB; b++)
        if (wr_mask[b])
          mem[wr_addr][b*SRAM_BYTE_W +: SRAM_BYTE_W] <= wr_data[b*SRAM_BYTE_W +: SRAM_BYTE_W];
    end
  end

  logic [RD_LAT:1]                 vld_pipe;
  logic [RD_LAT:1]                 col_pipe;
  logic [RD_LAT:1][DATA_WIDTH-1:0] dat_pipe;

  // Read pipeline: data is captured at request time so later writes cannot
  // disturb in-flight reads; each stage only loads behind a valid, so the
  // output stage holds its last value when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      col_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= rd_fire;
      if (rd_fire) begin
        dat_pipe[1] <= merged;
        col_pipe[1] <= hit;
      end
      for (int k = 2; k <= RD_LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        if (vld_pipe[k-1]) begin
          dat_pipe[k] <= dat_pipe[k-1];
          col_pipe[k] <= col_pipe[k-1];
        end
      end
    end
  end

  assign rd_data  = dat_pipe[RD_LAT];
  assign rd_valid = vld_pipe[RD_LAT];
  assign coll     = vld_pipe[RD_LAT] & col_pipe[RD_LAT];
endmodule
